// File: rtl/flex_counter.sv
// Synchronous up-counter counting 1..rollover_val then wrapping to 1, with
// synchronous clear, count enable and a registered terminal-count flag.
module flex_counter #(
  parameter int unsigned NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);

  logic [NUM_CNT_BITS-1:0] r_count;
  logic                    r_flag;
  logic [NUM_CNT_BITS-1:0] w_next;

  // >= also recovers when rollover_val is lowered below the current count
  always_comb begin
    w_next = r_count;
    if (count_enable) begin
      if (r_count >= rollover_val) begin
        w_next = NUM_CNT_BITS'(1);
      end else begin
        w_next = r_count + NUM_CNT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else if (clear) begin
      r_count <= '0;
      r_flag  <= 1'b0;
    end else begin
      r_count <= w_next;
      r_flag  <= (w_next == rollover_val);
    end
  end

  assign count_out     = r_count;
  assign rollover_flag = r_flag;

endmodule

// File: tb/tb_flex_counter.sv
// Scoreboard bench for flex_counter: stimulus pushes hand-computed expectations,
// a separate monitor pops and compares one entry after every clock edge.
module tb_flex_counter;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         clear = 1'b0;
  logic         count_enable = 1'b0;
  logic [W-1:0] rollover_val = '0;
  logic [W-1:0] count_out;
  logic         rollover_flag;

  typedef struct {
    logic [W-1:0] cnt;
    logic         flag;
    string        name;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  flex_counter #(.NUM_CNT_BITS(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .count_enable (count_enable),
    .rollover_val (rollover_val),
    .count_out    (count_out),
    .rollover_flag(rollover_flag)
  );

  always #5 clk = ~clk;

  // Monitor: outputs settle after each rising edge; compare against queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (count_out !== e.cnt || rollover_flag !== e.flag) begin
          n_bad++;
          $display("FAIL %s: got count=%0d flag=%b, expected count=%0d flag=%b",
                   e.name, count_out, rollover_flag, e.cnt, e.flag);
        end
      end
    end
  end

  task automatic drive(input logic r, input logic c, input logic en, input logic [W-1:0] rv,
                       input logic [W-1:0] ec, input logic ef, input string name);
    exp_t e;
    @(negedge clk);
    rst          = r;
    clear        = c;
    count_enable = en;
    rollover_val = rv;
    e.cnt  = ec;
    e.flag = ef;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic do_reset(input logic [W-1:0] rv);
    drive(1'b1, 1'b0, 1'b0, rv, 4'd0, 1'b0, "reset");
  endtask

  initial begin
    // Reset held two edges with enable high, then one idle edge after release
    drive(1'b1, 1'b0, 1'b1, 4'd6, 4'd0, 1'b0, "reset_edge1");
    drive(1'b1, 1'b0, 1'b1, 4'd6, 4'd0, 1'b0, "reset_edge2");
    drive(1'b0, 1'b0, 1'b0, 4'd6, 4'd0, 1'b0, "after_reset");

    // Rollover 6: 1..5 flag low, 6 flag high, then wrap to 1
    for (int k = 1; k <= 5; k++) drive(1'b0, 1'b0, 1'b1, 4'd6, 4'(k), 1'b0, "r6_count");
    drive(1'b0, 1'b0, 1'b1, 4'd6, 4'd6, 1'b1, "r6_terminal");
    drive(1'b0, 1'b0, 1'b1, 4'd6, 4'd1, 1'b0, "r6_wrap");

    // Rollover 7 continuous, two full periods
    do_reset(4'd7);
    for (int p = 0; p < 2; p++) begin
      for (int k = 1; k <= 6; k++) drive(1'b0, 1'b0, 1'b1, 4'd7, 4'(k), 1'b0, "r7_count");
      drive(1'b0, 1'b0, 1'b1, 4'd7, 4'd7, 1'b1, "r7_terminal");
    end
    // Hold at terminal keeps flag, re-enable wraps
    drive(1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b1, "r7_hold1");
    drive(1'b0, 1'b0, 1'b0, 4'd7, 4'd7, 1'b1, "r7_hold2");
    drive(1'b0, 1'b0, 1'b1, 4'd7, 4'd1, 1'b0, "r7_resume_wrap");

    // Clear while counting
    do_reset(4'd4);
    for (int k = 1; k <= 3; k++) drive(1'b0, 1'b0, 1'b1, 4'd4, 4'(k), 1'b0, "r4_count");
    drive(1'b0, 1'b0, 1'b1, 4'd4, 4'd4, 1'b1, "r4_terminal");
    drive(1'b0, 1'b1, 1'b1, 4'd4, 4'd0, 1'b0, "clear1");
    drive(1'b0, 1'b1, 1'b1, 4'd4, 4'd0, 1'b0, "clear2");
    drive(1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 1'b0, "post_clear_hold1");
    drive(1'b0, 1'b0, 1'b0, 4'd4, 4'd0, 1'b0, "post_clear_hold2");
    drive(1'b0, 1'b0, 1'b1, 4'd4, 4'd1, 1'b0, "post_clear_count");

    // rst and clear together
    drive(1'b1, 1'b1, 1'b1, 4'd4, 4'd0, 1'b0, "rst_and_clear");

    // Lower rollover below current count
    for (int k = 1; k <= 5; k++) drive(1'b0, 1'b0, 1'b1, 4'd7, 4'(k), 1'b0, "to5");
    drive(1'b0, 1'b0, 1'b1, 4'd3, 4'd1, 1'b0, "lowered_rv_wrap");
    drive(1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 1'b0, "lowered_rv_next");

    // Maximum rollover: no overflow to 0
    do_reset(4'd15);
    for (int k = 1; k <= 14; k++) drive(1'b0, 1'b0, 1'b1, 4'd15, 4'(k), 1'b0, "r15_count");
    drive(1'b0, 1'b0, 1'b1, 4'd15, 4'd15, 1'b1, "r15_terminal");
    drive(1'b0, 1'b0, 1'b1, 4'd15, 4'd1, 1'b0, "r15_wrap");

    // Illegal rollover 0: hold at 0 raises flag, enable escapes to 1
    do_reset(4'd0);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, "rv0_hold");
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, "rv0_escape");
    drive(1'b0, 1'b0, 1'b1, 4'd0, 4'd1, 1'b0, "rv0_stay1");

    // Mid-count reset, then resume
    drive(1'b0, 1'b0, 1'b1, 4'd9, 4'd2, 1'b0, "pre_rst");
    drive(1'b1, 1'b0, 1'b1, 4'd9, 4'd0, 1'b0, "mid_rst");
    drive(1'b0, 1'b0, 1'b1, 4'd9, 4'd1, 1'b0, "post_rst");

    // Drain the scoreboard within a bounded number of edges
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
